sigmoid_arbiter: RTL and testbench

Round-robin arbiter that shares one pipelined `sigmoid` core among `N_REQ` requesters. It accepts 8-bit operands over per-requester valid/ready handshakes and issues at most one operand per cycle to the core. It tracks which requester owns each in-flight operation and returns each 16-bit result into that requester's single-entry response buffer. It sits between the requester front-ends and the `sigmoid` instance; the core itself is external.

---
 rtl/sigmoid_arb_pkg.sv | 19 +
 rtl/sigmoid_arbiter_rr_picker.sv | 32 +++
 rtl/sigmoid_arbiter.sv | 147 ++++++++++++++
 tb/tb_sigmoid_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sigmoid_arb_pkg.sv
// Shared constants and types for the sigmoid core arbiter.
package sigmoid_arb_pkg;

    localparam int X_W       = 8;
    localparam int Y_W       = 16;
    localparam int N_REQ_MAX = 8;

    function automatic int tag_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int TAG_W_MAX = tag_w(N_REQ_MAX);

    typedef struct packed {
        logic                 valid;
        logic [TAG_W_MAX-1:0] tag;
    } tag_stage_t;

endpackage

// File: rtl/sigmoid_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap.
module rr_picker #(
    parameter int N  = 4,
    parameter int TW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [TW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [TW-1:0] idx,
    output logic          any
);

    logic [TW-1:0] pos_s;
    logic          hit_s;

    // scan from ptr upward; the first hit latches and masks later ones
    always_comb begin
        gnt   = '0;
        idx   = '0;
        any   = 1'b0;
        pos_s = '0;
        hit_s = 1'b0;
        for (int i = 0; i < N; i++) begin
            pos_s      = TW'((int'(ptr) + i) % N);
            hit_s      = req[pos_s] & ~any;
            gnt[pos_s] = hit_s;
            idx        = hit_s ? pos_s : idx;
            any        = any | hit_s;
        end
    end

endmodule

// File: rtl/sigmoid_arbiter.sv
// Round-robin arbiter sharing one pipelined sigmoid core among N_REQ requesters.
// Optional issue counter enabled by defining SIGMOID_ARB_CNT_EN.
module sigmoid_arbiter
    import sigmoid_arb_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int CORE_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     i_req_valid,
    input  logic [X_W*N_REQ-1:0] i_req_x,
    output logic [N_REQ-1:0]     o_req_ready,
    output logic [N_REQ-1:0]     o_rsp_valid,
    output logic [Y_W*N_REQ-1:0] o_rsp_y,
    input  logic [N_REQ-1:0]     i_rsp_ready,
    output logic                 o_core_in_valid,
    output logic [X_W-1:0]       o_core_x,
    input  logic [Y_W-1:0]       i_core_y,
    input  logic                 i_core_out_valid,
    output logic                 o_err,
    output logic [15:0]          o_issue_cnt
);

    localparam int TW = tag_w(N_REQ);
    localparam logic [N_REQ-1:0] ONE_V = {{(N_REQ-1){1'b0}}, 1'b1};

    logic [TW-1:0]               ptr_r;
    logic [N_REQ-1:0]            inflight_r;
    logic [N_REQ-1:0]            rsp_valid_r;
    logic [N_REQ-1:0][Y_W-1:0]   rsp_y_r;
    logic                        err_r;
    tag_stage_t                  pipe_r [CORE_LAT];

    logic [N_REQ-1:0]            elig_s;
    logic [N_REQ-1:0]            gnt_s;
    logic [TW-1:0]               gnt_idx_s;
    logic                        gnt_any_s;
    logic [TW-1:0]               next_ptr_s;
    tag_stage_t                  head_s;
    logic [TW-1:0]               head_tag_s;
    logic [N_REQ-1:0]            retire_s;
    logic [N_REQ-1:0]            capture_s;
    logic                        fault_s;

    // a pending pop still counts as busy: no same-cycle bypass
    assign elig_s = i_req_valid & ~(inflight_r | rsp_valid_r);

    rr_picker #(.N(N_REQ), .TW(TW)) u_picker (
        .req (elig_s),
        .ptr (ptr_r),
        .gnt (gnt_s),
        .idx (gnt_idx_s),
        .any (gnt_any_s)
    );

    assign head_s     = pipe_r[CORE_LAT-1];
    assign head_tag_s = TW'(head_s.tag);

    // issue path, next pointer, retire/capture vectors and protocol faults
    always_comb begin
        o_core_in_valid = gnt_any_s;
        o_core_x        = '0;
        next_ptr_s      = ptr_r;
        retire_s        = '0;
        capture_s       = '0;
        if (gnt_any_s) begin
            o_core_x   = i_req_x[int'(gnt_idx_s)*X_W +: X_W];
            next_ptr_s = (int'(gnt_idx_s) == N_REQ-1) ? '0 : gnt_idx_s + TW'(1);
        end else begin
            o_core_x   = '0;
            next_ptr_s = ptr_r;
        end
        if (head_s.valid) begin
            retire_s  = ONE_V << head_tag_s;
            capture_s = i_core_out_valid ? retire_s : '0;
        end else begin
            retire_s  = '0;
            capture_s = '0;
        end
        fault_s = (head_s.valid ^ i_core_out_valid)
                | (head_s.valid & (int'(head_s.tag) >= N_REQ));
    end

    // round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= '0;
        end else if (gnt_any_s) begin
            ptr_r <= next_ptr_s;
        end
    end

    // tag pipeline mirroring the core's latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CORE_LAT; i++) begin
                pipe_r[i] <= '0;
            end
        end else begin
            pipe_r[0] <= '{valid: gnt_any_s, tag: TAG_W_MAX'(gnt_idx_s)};
            for (int i = 1; i < CORE_LAT; i++) begin
                pipe_r[i] <= pipe_r[i-1];
            end
        end
    end

    // ownership, response buffers and sticky error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_r  <= '0;
            rsp_valid_r <= '0;
            rsp_y_r     <= '0;
            err_r       <= 1'b0;
        end else begin
            inflight_r  <= (inflight_r & ~retire_s) | gnt_s;
            rsp_valid_r <= (rsp_valid_r & ~i_rsp_ready) | capture_s;
            if (|capture_s) begin
                rsp_y_r[head_tag_s] <= i_core_y;
            end
            err_r <= err_r | fault_s;
        end
    end

    assign o_req_ready = gnt_s;
    assign o_rsp_valid = rsp_valid_r;
    assign o_rsp_y     = rsp_y_r;
    assign o_err       = err_r;

`ifdef SIGMOID_ARB_CNT_EN
    logic [15:0] cnt_r;

    // issue counter, wraps at 16 bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= 16'h0000;
        end else if (gnt_any_s) begin
            cnt_r <= cnt_r + 16'h0001;
        end
    end

    assign o_issue_cnt = cnt_r;
`else
    assign o_issue_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_sigmoid_arbiter.sv
// Self-checking bench for sigmoid_arbiter with a one-cycle core model and a
// transaction-level reference of grants, ownership and response buffers.
module tb_sigmoid_arbiter;

    localparam int N   = 4;
    localparam int LAT = 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [8*N-1:0]  req_x = '0;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic [16*N-1:0] rsp_y;
    logic [N-1:0]    rsp_ready = '0;
    logic            core_in_valid;
    logic [7:0]      core_x;
    logic [15:0]     core_y;
    logic            core_ov;
    logic            err;
    logic [15:0]     issue_cnt;
    logic            drop_req = 1'b0;
    logic            spur_req = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sigmoid_arbiter #(.N_REQ(N), .CORE_LAT(LAT)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_req_valid      (req_valid),
        .i_req_x          (req_x),
        .o_req_ready      (req_ready),
        .o_rsp_valid      (rsp_valid),
        .o_rsp_y          (rsp_y),
        .i_rsp_ready      (rsp_ready),
        .o_core_in_valid  (core_in_valid),
        .o_core_x         (core_x),
        .i_core_y         (core_y),
        .i_core_out_valid (core_ov),
        .o_err            (err),
        .o_issue_cnt      (issue_cnt)
    );

    function automatic logic [15:0] sig_f(input logic [7:0] x);
        return {x ^ 8'h5A, x + 8'd3};
    endfunction

    // core model: one cycle latency, with drop/spurious fault injection
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_ov <= 1'b0;
            core_y  <= 16'h0000;
        end else begin
            core_ov <= (core_in_valid & ~drop_req) | spur_req;
            core_y  <= core_in_valid ? sig_f(core_x) : 16'h0000;
        end
    end

    // reference state
    int          m_ptr;
    bit          m_inflight [N];
    int          m_due [N];
    logic [7:0]  m_x [N];
    bit          m_rv [N];
    logic [15:0] m_y [N];
    bit          m_err;
    int          m_cnt;
    int          cyc_n;
    int          last_g;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_err = 0; m_cnt = 0; cyc_n = 0; last_g = -1;
        for (int k = 0; k < N; k++) begin
            m_inflight[k] = 0; m_due[k] = 0; m_x[k] = 8'h00; m_rv[k] = 0; m_y[k] = 16'h0000;
        end
    endtask

    task automatic to_neg();
        @(negedge clk);
    endtask

    // compare this cycle's outputs with the reference, then advance it
    task automatic finish_cycle();
        int g;
        int k;
        bit any_due;
        logic [N-1:0]    e_ready;
        logic [N-1:0]    e_rv;
        logic [7:0]      e_cx;
        logic [16*N-1:0] e_y;
        g = -1;
        for (int i = 0; i < N; i++) begin
            k = (m_ptr + i) % N;
            if (g < 0 && req_valid[k] && !m_inflight[k] && !m_rv[k]) g = k;
        end
        e_ready = '0;
        e_cx = 8'h00;
        if (g >= 0) begin
            e_ready[g] = 1'b1;
            e_cx = req_x[g*8 +: 8];
        end
        for (int j = 0; j < N; j++) begin
            e_rv[j] = m_rv[j];
            e_y[j*16 +: 16] = m_y[j];
        end
        chk("ready", req_ready, e_ready);
        chk("core_valid", core_in_valid, (g >= 0) ? 1 : 0);
        chk("core_x", core_x, e_cx);
        chk("rsp_valid", rsp_valid, e_rv);
        chk("rsp_y", rsp_y, e_y);
        chk("err", err, m_err);
`ifdef SIGMOID_ARB_CNT_EN
        chk("issue_cnt", issue_cnt, m_cnt);
`else
        chk("issue_cnt", issue_cnt, 0);
`endif
        last_g = g;
        for (int j = 0; j < N; j++) begin
            if (m_rv[j] && rsp_ready[j]) m_rv[j] = 0;
        end
        any_due = 0;
        for (int j = 0; j < N; j++) begin
            if (m_inflight[j] && m_due[j] == cyc_n) begin
                any_due = 1;
                m_inflight[j] = 0;
                if (core_ov) begin
                    m_rv[j] = 1;
                    m_y[j] = sig_f(m_x[j]);
                end else begin
                    m_err = 1;
                end
            end
        end
        if (!any_due && core_ov) m_err = 1;
        if (g >= 0) begin
            m_inflight[g] = 1;
            m_due[g] = cyc_n + LAT;
            m_x[g] = e_cx;
            m_ptr = (g + 1) % N;
            m_cnt = (m_cnt + 1) % 65536;
        end
        cyc_n++;
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        to_neg();
        finish_cycle();
    endtask

    task automatic do_reset();
        req_valid = '0; rsp_ready = '0; drop_req = 1'b0; spur_req = 1'b0;
        rst_n = 1'b0;
        #3;
        chk("rst_ready", req_ready, 0);
        chk("rst_core_valid", core_in_valid, 0);
        chk("rst_core_x", core_x, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_y", rsp_y, 0);
        chk("rst_err", err, 0);
        chk("rst_cnt", issue_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
    endtask

    typedef struct {
        logic [3:0] rv;
        logic [3:0] rr;
        logic [3:0] e_ready;
        logic       e_cv;
        logic [7:0] e_cx;
        logic [3:0] e_rsp;
    } vec_t;

    vec_t tbl [6];

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int others;
        int issues;
        tbl[0] = '{4'b0100, 4'b1111, 4'b0100, 1'b1, 8'h40, 4'b0000};
        tbl[1] = '{4'b0100, 4'b1111, 4'b0000, 1'b0, 8'h00, 4'b0000};
        tbl[2] = '{4'b0100, 4'b1111, 4'b0000, 1'b0, 8'h00, 4'b0100};
        tbl[3] = '{4'b0100, 4'b1111, 4'b0100, 1'b1, 8'h40, 4'b0000};
        tbl[4] = '{4'b0000, 4'b1111, 4'b0000, 1'b0, 8'h00, 4'b0000};
        tbl[5] = '{4'b0000, 4'b1111, 4'b0000, 1'b0, 8'h00, 4'b0100};

        model_reset();
        #12;
        do_reset();

        // single requester, table driven
        req_x = 32'h00400000;
        for (int i = 0; i < 6; i++) begin
            req_valid = tbl[i].rv;
            rsp_ready = tbl[i].rr;
            to_neg();
            chk("t_ready", req_ready, tbl[i].e_ready);
            chk("t_core_valid", core_in_valid, tbl[i].e_cv);
            chk("t_core_x", core_x, tbl[i].e_cx);
            chk("t_rsp_valid", rsp_valid, tbl[i].e_rsp);
            if (tbl[i].e_rsp[2]) chk("t_y2", rsp_y[47:32], sig_f(8'h40));
            finish_cycle();
        end

        // all requesters continuously active
        do_reset();
        req_x = $urandom;
        for (int i = 0; i < 12; i++) begin
            req_valid = 4'b1111; rsp_ready = 4'b1111;
            to_neg();
            chk("rr_order", req_ready, 4'b0001 << (i % 4));
            finish_cycle();
        end

        // requester 1 stalls its response buffer
        others = 0;
        for (int i = 0; i < 10; i++) begin
            req_valid = 4'b1111; rsp_ready = 4'b1101;
            to_neg();
            if (m_rv[1]) begin
                chk("hold_ready1", req_ready[1], 0);
                chk("hold_y1", rsp_y[31:16], sig_f(req_x[15:8]));
            end
            finish_cycle();
            if (last_g >= 0 && last_g != 1) others++;
        end
        chk("hold_buf1_full", rsp_valid[1], 1);
        chk("hold_others_served", (others >= 6) ? 1 : 0, 1);

        // dropped result, then spurious result
        do_reset();
        req_x = 32'h00000011; req_valid = 4'b0001; rsp_ready = 4'b1111; drop_req = 1'b1;
        to_neg();
        chk("f_issue", core_in_valid, 1);
        finish_cycle();
        drop_req = 1'b0; req_valid = 4'b0000;
        to_neg();
        chk("f_err_pre", err, 0);
        finish_cycle();
        req_valid = 4'b0001;
        to_neg();
        chk("f_err", err, 1);
        chk("f_regrant", req_ready, 4'b0001);
        chk("f_no_rsp", rsp_valid, 0);
        finish_cycle();
        req_valid = 4'b0000;
        for (int i = 0; i < 4; i++) step();
        spur_req = 1'b1;
        step();
        spur_req = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("f_err_sticky", err, 1);

        do_reset();
        step();
        spur_req = 1'b1;
        step();
        spur_req = 1'b0;
        to_neg();
        chk("s_err_pre", err, 0);
        finish_cycle();
        to_neg();
        chk("s_err", err, 1);
        finish_cycle();

        // reset with work in flight
        do_reset();
        req_valid = 4'b0011; rsp_ready = 4'b0000; req_x = 32'h00003322;
        step();
        step();
        do_reset();
        req_valid = 4'b0110;
        to_neg();
        chk("post_rst_grant", req_ready, 4'b0010);
        finish_cycle();

        // randomized traffic
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            req_valid = 4'($urandom);
            req_x = $urandom;
            for (int k = 0; k < N; k++) rsp_ready[k] = ($urandom_range(0, 3) != 0);
            step();
        end
`ifndef SIGMOID_ARB_CNT_EN
        chk("cnt_off", issue_cnt, 0);
`endif

`ifdef SIGMOID_ARB_CNT_EN
        do_reset();
        issues = 0;
        req_valid = 4'b1111; rsp_ready = 4'b1111;
        for (int i = 0; i < 70000 && issues < 65537; i++) begin
            step();
            if (last_g >= 0) issues++;
        end
        chk("cnt_issues", issues, 65537);
        req_valid = 4'b0000;
        to_neg();
        chk("cnt_wrap", issue_cnt, 16'd1);
        finish_cycle();
`else
        issues = 0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
